ahb_input_hold_stage: RTL
=========================

Name: ahb_input_hold_stage

Overview:
Per-master input stage of the AHB bus matrix; it sits between one master-side AHB slave interface and the output-port arbiters.
- Holds an address-phase transfer that the target output port cannot accept yet.
- Drives the request seen by the output arbiters.
- Stalls the master with HREADYOUTS until the held transfer is granted and its data phase completes.
- Routes data-phase ready/response back to the master. Write/read data are routed externally and are not handled here.

Parameters:
ADDR_W, 32, address width
PROT_W, 4, HPROT width

Ports:
HCLK  in  1  AHB system clock
HRESET  in  1  reset, asynchronous, active-high
HSELS  in  1  master-side select
HADDRS  in  ADDR_W  master address
HTRANSS  in  2  master transfer type
HWRITES  in  1  master write
HSIZES  in  3  master size
HBURSTS  in  3  master burst
HPROTS  in  PROT_W  master protection
HMASTLOCKS  in  1  master lock
HREADYS  in  1  bus HREADY seen by master (address sample qualifier)
HREADYOUTS  out  1  ready to master
HRESPS  out  1  response to master (0 OKAY, 1 ERROR)
HADDRI  out  ADDR_W  address to decoder/output stages
HTRANSI  out  2  transfer to output stages
HWRITEI  out  1  write to output stages
HSIZEI  out  3  size to output stages
HBURSTI  out  3  burst to output stages
HPROTI  out  PROT_W  protection to output stages
HMASTLOCKI  out  1  lock to output stages
req_out  out  1  active transfer request to output arbiters
grant_in  in  1  output stage accepted this port's address phase this cycle (already qualified by output HREADY)
dp_ready_in  in  1  HREADYOUT of the slave owning this port's data phase
dp_resp_in  in  1  HRESP of that slave

Behaviour:
- sample = HSELS & HREADYS; live_valid = sample & HTRANSS[1] (NONSEQ/SEQ).
- Holding register captures all address/control signals on the edge where live_valid & ~grant_in.
- Output mux: in PEND, the I-side outputs come from the holding register. Otherwise they are the live inputs, with HTRANSI forced to IDLE (2'b00) when ~sample.
- req_out = (state==PEND) | live_valid. This is combinational with zero latency.

State machine (3 states, reset to IDLE):
- IDLE (no data phase owned): HREADYOUTS=1, HRESPS=0.
  - live_valid & grant_in -> DATA.
  - live_valid & ~grant_in -> PEND.
  - sample of IDLE/BUSY, or no sample -> stay in IDLE; the master gets a zero-wait OKAY.
- PEND (held transfer, no data phase): HREADYOUTS=0, HRESPS=0. The master's address inputs are ignored (HREADYS is low).
  - grant_in -> DATA.
  - else stay in PEND. A held transfer is never dropped, even if HSELS deasserts.
- DATA (data phase owned): HREADYOUTS=dp_ready_in, HRESPS=dp_resp_in.
  - ~dp_ready_in -> stay in DATA.
  - dp_ready_in: evaluate the new address exactly as in IDLE (-> DATA, PEND, or IDLE).
- ERROR handling: the two-cycle ERROR is passed through from the slave. On the first ERROR cycle HREADY is low, so nothing is sampled. A master IDLE issued on the second cycle returns the FSM to IDLE.
- HMASTLOCKI is held with the transfer, so the arbiters see the lock while in PEND.
- Reset asserted mid-operation: immediately IDLE, holding register cleared to 0, HREADYOUTS=1, HRESPS=0, req_out=0.
- Reset values: HREADYOUTS=1, HRESPS=0, req_out=0. All I-side outputs are 0, except that they follow the live inputs when sample.
- No X on outputs when HTRANSS is a legal value.

Decomposition:
- Shared package ahb_matrix_pkg: HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ), HRESP encodings, FSM state enum.
- One sub-module, ahb_addr_hold_reg: the enable-captured address/control register with an active-high async clear.

Test Plan:
1. Reset pulse mid-PEND (HADDRS=0x2000_0000 held) -> next cycle HREADYOUTS=1, req_out=0, state IDLE, HADDRI=0 with HSELS=0.
2. NONSEQ to 0x1000_0004 with grant_in=1 same cycle, dp_ready_in low 2 cycles -> req_out=1 in cycle 0; HREADYOUTS=0,0 then 1; no PEND entered.
3. NONSEQ to 0x1000_0008 with grant_in=0 for 3 cycles, HADDRS changed to 0xDEAD_BEEF after the capture edge -> HADDRI stays 0x1000_0008; HTRANSI=NONSEQ; req_out=1; HREADYOUTS=0 for 3 cycles, then DATA on grant.
4. HSELS=1, HTRANSS=IDLE -> req_out=0, HREADYOUTS=1, HRESPS=0 next cycle (zero-wait OKAY).
5. DATA with dp_resp_in=1 for 2 cycles (dp_ready_in 0 then 1), master issues IDLE on cycle 2 -> HRESPS=1,1; HREADYOUTS=0,1; FSM returns to IDLE.
6. Back-to-back: INCR4 SEQ beat presented while DATA completes and grant_in=0 (arbiter serving another port) -> PEND captures SEQ with HBURSTI=3'b011 and HMASTLOCKI preserved; transfer completes after grant.

Source files
------------

// File: rtl/ahb_matrix_pkg.sv
// Shared AHB bus-matrix encodings: HTRANS/HRESP codes and input-stage FSM states.
package ahb_matrix_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // IDLE: no data phase owned; PEND: address phase held; DATA: data phase owned
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PEND = 2'b01,
    ST_DATA = 2'b10
  } hold_state_t;

endpackage

// File: rtl/ahb_addr_hold_reg.sv
// Enable-captured address/control holding register with async active-high clear.
module ahb_addr_hold_reg #(
  parameter int W = 1
) (
  input  logic         HCLK,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Capture the flattened address/control bundle when enabled; clear on reset
  always_ff @(posedge HCLK or posedge clr) begin
    if (clr)     q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/ahb_input_hold_stage.sv
// Per-master input stage of the AHB matrix: holds an address phase that the
// output port cannot accept yet, stalls the master until the held transfer's
// data phase completes, and routes data-phase ready/response back.
module ahb_input_hold_stage
  import ahb_matrix_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int PROT_W = 4
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSELS,
  input  logic [ADDR_W-1:0] HADDRS,
  input  logic [1:0]        HTRANSS,
  input  logic              HWRITES,
  input  logic [2:0]        HSIZES,
  input  logic [2:0]        HBURSTS,
  input  logic [PROT_W-1:0] HPROTS,
  input  logic              HMASTLOCKS,
  input  logic              HREADYS,
  output logic              HREADYOUTS,
  output logic              HRESPS,
  output logic [ADDR_W-1:0] HADDRI,
  output logic [1:0]        HTRANSI,
  output logic              HWRITEI,
  output logic [2:0]        HSIZEI,
  output logic [2:0]        HBURSTI,
  output logic [PROT_W-1:0] HPROTI,
  output logic              HMASTLOCKI,
  output logic              req_out,
  input  logic              grant_in,
  input  logic              dp_ready_in,
  input  logic              dp_resp_in
);

  localparam int BUS_W = ADDR_W + 2 + 1 + 3 + 3 + PROT_W + 1;

  hold_state_t state, state_nxt;

  logic             sample, live_valid, accept, capture;
  logic [BUS_W-1:0] live_bus, hold_bus, out_bus;

  assign sample     = HSELS & HREADYS;
  assign live_valid = sample & HTRANSS[1];

  // A new address is only evaluated when no transfer is held and any owned
  // data phase is completing; this keeps a misbehaving master from
  // overwriting the held transfer.
  assign accept  = (state == ST_IDLE) | ((state == ST_DATA) & dp_ready_in);
  assign capture = accept & live_valid & ~grant_in;

  assign live_bus = {HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTLOCKS};

  ahb_addr_hold_reg #(.W(BUS_W)) u_hold (
    .HCLK (HCLK),
    .clr  (HRESET),
    .en   (capture),
    .d    (live_bus),
    .q    (hold_bus)
  );

  // Held transfer wins; otherwise live inputs, zeroed (HTRANSI=IDLE) when not sampled
  always_comb begin
    out_bus = '0;
    if (state == ST_PEND) out_bus = hold_bus;
    else if (sample)      out_bus = live_bus;
  end

  assign {HADDRI, HTRANSI, HWRITEI, HSIZEI, HBURSTI, HPROTI, HMASTLOCKI} = out_bus;

  assign req_out = (state == ST_PEND) | live_valid;

  // State register
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state and master-side ready/response
  always_comb begin
    state_nxt  = state;
    HREADYOUTS = 1'b1;
    HRESPS     = HRESP_OKAY;
    case (state)
      ST_IDLE: ;
      ST_PEND: begin
        HREADYOUTS = 1'b0;
        if (grant_in) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        HREADYOUTS = dp_ready_in;
        HRESPS     = dp_resp_in;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (accept) begin
      if (live_valid) state_nxt = grant_in ? ST_DATA : ST_PEND;
      else            state_nxt = ST_IDLE;
    end
  end

endmodule
